// File: rtl/uart_bcd_rx.sv
// UART receiver (7 data bits, odd parity) feeding a two-digit BCD record parser.
// Records are two ASCII digits terminated by CR. Every other sequence raises seq_err.
module uart_bcd_rx #(
  parameter int CLKS_PER_BIT = 278,
  parameter int HALF_BIT     = 139
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [6:0] rx_data,
  output logic       rx_strobe,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic       bcd_valid,
  output logic       par_err,
  output logic       frm_err,
  output logic       seq_err
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  localparam logic [8:0] BIT_LAST  = 9'(CLKS_PER_BIT - 1);
  localparam logic [8:0] HALF_LAST = 9'(HALF_BIT - 1);

  logic       s1_q, s2_q, rxs;
  logic [1:0] settle_q;
  logic       arm_q;
  state_t     state_q, state_d;
  logic [8:0] cnt_q;
  logic [2:0] idx_q;
  logic [6:0] shreg_q;
  logic       par_q;
  logic       tick, cnt_run;
  logic       smp_data, smp_par, stop_ok, stop_bad;
  logic       par_ok, is_digit;
  logic       ok_q, par_err_q, frm_err_q;
  logic [6:0] rx_data_q;
  logic       rx_strobe_q, bcd_valid_q, seq_err_q;
  logic [3:0] hi_q, lo_q, bcd1_q, bcd0_q;
  logic [1:0] dcnt_q;

  assign rxs = s2_q;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= rx_in;
      s2_q <= s1_q;
    end
  end

  // Arm only after the synchronizer has refilled and the line was seen high,
  // so a frame interrupted by reset cannot be mistaken for a fresh start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_q <= 2'd0;
      arm_q    <= 1'b0;
    end else begin
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      arm_q <= arm_q | (settle_q[1] & rxs);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (arm_q && !rxs) state_d = START;
      START:     if (tick) state_d = rxs ? IDLE : DATA;
      DATA:      if (tick && idx_q == 3'd6) state_d = PARITY;
      PARITY:    if (tick) state_d = STOP;
      STOP:      if (tick) state_d = rxs ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rxs) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs: bit-timing terminal count and per-bit sample strobes
  always_comb begin
    tick     = 1'b0;
    cnt_run  = 1'b0;
    smp_data = 1'b0;
    smp_par  = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      START: begin
        cnt_run = 1'b1;
        tick    = (cnt_q == HALF_LAST);
      end
      DATA: begin
        cnt_run  = 1'b1;
        tick     = (cnt_q == BIT_LAST);
        smp_data = tick;
      end
      PARITY: begin
        cnt_run = 1'b1;
        tick    = (cnt_q == BIT_LAST);
        smp_par = tick;
      end
      STOP: begin
        cnt_run  = 1'b1;
        tick     = (cnt_q == BIT_LAST);
        stop_ok  = tick & rxs;
        stop_bad = tick & ~rxs;
      end
      default: ;
    endcase
  end

  // Bit timer, data bit index and shift/parity capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 9'd0;
      idx_q   <= 3'd0;
      shreg_q <= 7'd0;
      par_q   <= 1'b0;
    end else begin
      cnt_q <= (!cnt_run || tick) ? 9'd0 : cnt_q + 9'd1;
      if (state_q != DATA) idx_q <= 3'd0;
      else if (smp_data)   idx_q <= idx_q + 3'd1;
      if (smp_data) shreg_q[idx_q] <= rxs;
      if (smp_par)  par_q <= rxs;
    end
  end

  assign par_ok   = ^{shreg_q, par_q};
  assign is_digit = (shreg_q[6:4] == 3'b011) && (shreg_q[3:0] <= 4'd9);

  // Frame verdict, registered one cycle after the stop-bit sample
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_q      <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      ok_q      <= stop_ok & par_ok;
      par_err_q <= stop_ok & ~par_ok;
      frm_err_q <= stop_bad;
    end
  end

  // Character delivery and BCD record parsing
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q   <= 7'd0;
      rx_strobe_q <= 1'b0;
      bcd_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      hi_q        <= 4'd0;
      lo_q        <= 4'd0;
      bcd1_q      <= 4'd0;
      bcd0_q      <= 4'd0;
      dcnt_q      <= 2'd0;
    end else begin
      rx_strobe_q <= ok_q;
      bcd_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      if (ok_q) begin
        rx_data_q <= shreg_q;
        if (is_digit) begin
          hi_q <= lo_q;
          lo_q <= shreg_q[3:0];
          if (dcnt_q != 2'd3) dcnt_q <= dcnt_q + 2'd1;
        end else if (shreg_q == 7'h0D && dcnt_q == 2'd2) begin
          bcd1_q      <= hi_q;
          bcd0_q      <= lo_q;
          bcd_valid_q <= 1'b1;
          dcnt_q      <= 2'd0;
        end else begin
          seq_err_q <= 1'b1;
          dcnt_q    <= 2'd0;
        end
      end
      if (stop_ok && !par_ok) dcnt_q <= 2'd0;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_strobe = rx_strobe_q;
  assign bcd1      = bcd1_q;
  assign bcd0      = bcd0_q;
  assign bcd_valid = bcd_valid_q;
  assign par_err   = par_err_q;
  assign frm_err   = frm_err_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_uart_bcd_rx.sv
// Bench for uart_bcd_rx: directed scenarios plus randomized frames,
// checked against a queue-based model of the record parser.
module tb_uart_bcd_rx;

  localparam int CPB    = 64;
  localparam int HB     = 32;
  localparam int BIT_NS = CPB * 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [6:0] rx_data;
  logic       rx_strobe;
  logic [3:0] bcd1, bcd0;
  logic       bcd_valid, par_err, frm_err, seq_err;

  uart_bcd_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HB)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in),
    .rx_data(rx_data), .rx_strobe(rx_strobe),
    .bcd1(bcd1), .bcd0(bcd0), .bcd_valid(bcd_valid),
    .par_err(par_err), .frm_err(frm_err), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Observed pulse counts, sampled on the falling edge
  int n_strobe = 0, n_valid = 0, n_par = 0, n_frm = 0, n_seq = 0;
  logic [6:0] got_q[$];

  always @(negedge clk) begin
    if (rx_strobe) begin
      n_strobe <= n_strobe + 1;
      got_q.push_back(rx_data);
    end
    if (bcd_valid) n_valid <= n_valid + 1;
    if (par_err)   n_par   <= n_par + 1;
    if (frm_err)   n_frm   <= n_frm + 1;
    if (seq_err)   n_seq   <= n_seq + 1;
  end

  // Reference model
  int e_strobe = 0, e_valid = 0, e_par = 0, e_frm = 0, e_seq = 0;
  logic [6:0] e_data = 7'd0;
  logic [3:0] e_b1 = 4'd0, e_b0 = 4'd0;
  int dq[$];
  logic [6:0] e_chars[$];

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_good(input logic [6:0] ch);
    e_strobe++;
    e_data = ch;
    e_chars.push_back(ch);
    if (ch >= 7'h30 && ch <= 7'h39) begin
      dq.push_back(int'(ch) - 48);
    end else if (ch == 7'h0D) begin
      if (dq.size() == 2) begin
        e_b1 = 4'(dq[0]);
        e_b0 = 4'(dq[1]);
        e_valid++;
      end else begin
        e_seq++;
      end
      dq.delete();
    end else begin
      e_seq++;
      dq.delete();
    end
  endtask

  task automatic send_frame(input logic [6:0] ch, input logic par_flip,
                            input logic stop_bit, input int bit_ns);
    rx_in = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 7; i++) begin
      rx_in = ch[i];
      #(bit_ns);
    end
    rx_in = (~^ch) ^ par_flip;
    #(bit_ns);
    rx_in = stop_bit;
    #(bit_ns);
  endtask

  task automatic send_good(input logic [6:0] ch, input int bit_ns);
    send_frame(ch, 1'b0, 1'b1, bit_ns);
    model_good(ch);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".strobes"}, n_strobe, e_strobe);
    chk({tag, ".rx_data"}, rx_data, e_data);
    chk({tag, ".bcd1"}, bcd1, e_b1);
    chk({tag, ".bcd0"}, bcd0, e_b0);
    chk({tag, ".valids"}, n_valid, e_valid);
    chk({tag, ".par_err"}, n_par, e_par);
    chk({tag, ".frm_err"}, n_frm, e_frm);
    chk({tag, ".seq_err"}, n_seq, e_seq);
  endtask

  int skew;
  int r;
  logic [6:0] ch;

  initial begin
    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst.rx_data", rx_data, 7'd0);
    chk("rst.bcd1", bcd1, 4'd0);
    chk("rst.bcd0", bcd0, 4'd0);
    chk("rst.pulses",
        {rx_strobe, bcd_valid, par_err, frm_err, seq_err}, 5'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #(BIT_NS);

    // '4' '7' CR -> record 4,7
    send_good(7'h34, BIT_NS);
    send_good(7'h37, BIT_NS);
    send_good(7'h0D, BIT_NS);
    #(2 * BIT_NS);
    check_all("rec47");

    // Bad parity
    send_frame(7'h34, 1'b1, 1'b1, BIT_NS);
    e_par++;
    dq.delete();
    #(2 * BIT_NS);
    check_all("badpar");

    // Short low glitch, then a normal frame
    rx_in = 1'b0;
    #(120);
    rx_in = 1'b1;
    #(BIT_NS);
    check_all("glitch");
    send_good(7'h35, BIT_NS);
    #(2 * BIT_NS);
    check_all("postglitch");

    // Stop bit 0 followed by a held-low line
    send_frame(7'h31, 1'b0, 1'b0, BIT_NS);
    #(5 * BIT_NS);
    rx_in = 1'b1;
    e_frm++;
    #(2 * BIT_NS);
    check_all("break");

    // Clear digit history, then sequence errors and a good record
    send_good(7'h0D, BIT_NS);
    send_good(7'h31, BIT_NS);
    send_good(7'h0D, BIT_NS);
    #(2 * BIT_NS);
    check_all("seq1cr");
    send_good(7'h41, BIT_NS);
    #(2 * BIT_NS);
    check_all("seqA");
    send_good(7'h39, BIT_NS);
    send_good(7'h30, BIT_NS);
    send_good(7'h0D, BIT_NS);
    #(2 * BIT_NS);
    check_all("rec90");

    // Reset in the middle of a frame
    fork
      send_frame(7'h00, 1'b0, 1'b1, BIT_NS);
      begin
        #(BIT_NS * 5 / 2);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
      end
    join
    e_data = 7'd0;
    e_b1   = 4'd0;
    e_b0   = 4'd0;
    dq.delete();
    #(2 * BIT_NS);
    check_all("midrst");
    send_good(7'h32, BIT_NS);
    #(2 * BIT_NS);
    check_all("postrst");

    // 30 back-to-back frames with per-frame baud skew
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       ch = 7'(7'h30 + $urandom_range(0, 9));
      else if (r < 8)  ch = 7'h0D;
      else             ch = 7'($urandom_range(0, 127));
      skew = $urandom_range(0, 2);
      send_good(ch, BIT_NS - 13 + 13 * skew);
    end
    #(2 * BIT_NS);
    check_all("b2b");

    // Random frames with gaps and occasional parity errors
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)       ch = 7'(7'h30 + $urandom_range(0, 9));
      else if (r < 7)  ch = 7'h0D;
      else             ch = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 4) == 0) begin
        send_frame(ch, 1'b1, 1'b1, BIT_NS);
        e_par++;
        dq.delete();
      end else begin
        send_good(ch, BIT_NS);
      end
      #($urandom_range(0, 3 * BIT_NS));
      #(2 * BIT_NS);
      check_all("rnd");
    end

    // Received character stream in order
    chk("stream.len", got_q.size(), e_chars.size());
    for (int i = 0; i < e_chars.size() && i < got_q.size(); i++)
      chk("stream.char", got_q[i], e_chars[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/uart_bcd_rx.md
UART_BCD_RX -- requirements
Module: uart_bcd_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 278, meaning clk cycles per bit (16 MHz / 57600).
REQ-002 SHALL have parameter HALF_BIT, default 139, meaning clk cycles from start-bit falling edge to mid-bit sample.
REQ-003 SHALL have port clk, input, 1, system clock (16 MHz); reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port rx_in, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data, output, 7, last received character.
REQ-007 SHALL have port rx_strobe, output, 1, one-cycle pulse when rx_data updates.
REQ-008 SHALL have port bcd1, output, 4, first (tens) digit of last valid record.
REQ-009 SHALL have port bcd0, output, 4, second (units) digit of last valid record.
REQ-010 SHALL have port bcd_valid, output, 1, one-cycle pulse when bcd1/bcd0 update.
REQ-011 SHALL have ports par_err, frm_err, seq_err, output, 1 each, one-cycle error pulses.

Function
REQ-012 SHALL pass rx_in through a 2-flop synchronizer; all logic uses the synchronized bit rxs.
REQ-013 Frame format SHALL be: start(0), 7 data bits LSB first, odd parity bit (total ones over data+parity odd), stop(1).
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; one bit-timing counter, 9 bits, with a 3-bit data bit index.
REQ-015 IDLE: on rxs==0, go to START and clear the counter.
REQ-016 START: after HALF_BIT cycles, sample rxs; if 0, go to DATA and restart the counter; if 1 (glitch), return to IDLE with no output and no error.
REQ-017 DATA: every CLKS_PER_BIT cycles, shift rxs into bit[index]; after bit 6, go to PARITY.
REQ-018 PARITY: after CLKS_PER_BIT cycles, sample the parity bit and go to STOP.
REQ-019 STOP: after CLKS_PER_BIT cycles, sample the stop bit (mid stop bit).
REQ-020 On a stop bit of 1, the FSM SHALL go straight to IDLE so that a zero-gap next start bit is caught.
REQ-021 On a stop bit of 0, the block SHALL pulse frm_err, discard the character, and go to WAIT_IDLE.
REQ-022 WAIT_IDLE SHALL remain until rxs==1, then go to IDLE; a held-low break yields exactly one frm_err.
REQ-023 On a good stop bit with a parity mismatch, the block SHALL pulse par_err, discard the character, and reset the digit count to 0.
REQ-024 On a good stop bit and good parity, the block SHALL, on the next clk, load rx_data and pulse rx_strobe; this is the only case in which rx_data changes.
REQ-025 Digit chars 0x30-0x39: the block SHALL shift them into the holding pair (hi<=lo; lo<=char[3:0]) and increment the digit count, saturating at 3.
REQ-026 CR 0x0D with digit count==2: the block SHALL set bcd1<=hi and bcd0<=lo, pulse bcd_valid in the same cycle as rx_strobe, and reset the count to 0.
REQ-027 CR with digit count!=2: the block SHALL pulse seq_err, leave bcd1/bcd0 unchanged, and reset the count to 0.
REQ-028 Any other valid char: the block SHALL pulse seq_err and reset the count to 0.
REQ-029 Errors SHALL never alter bcd1/bcd0, and at most one error pulse SHALL occur per frame.

Reset
REQ-030 While rst is high, the FSM SHALL be IDLE, counters 0, synchronizer flops 1, rx_data=0, bcd1=bcd0=0, and all pulses 0.
REQ-031 rst asserted mid-frame SHALL abort the frame silently; the frame remainder after release SHALL NOT produce rx_strobe unless a falling edge follows idle.

Verification
REQ-032 Send '4'(0x34,p=0), '7'(0x37,p=0), CR(0x0D,p=0) at 57600 -> three rx_strobe pulses; bcd_valid with the third; bcd1=4, bcd0=7; no errors.
REQ-033 Send 0x34 with parity bit 1 -> par_err pulse, no rx_strobe; rx_data unchanged.
REQ-034 Hold rx_in low 50 cycles then high -> no rx_strobe, no error; the following good frame is received normally.
REQ-035 Send 0x31 with stop bit 0, line then held low 5 bit-times -> exactly one frm_err; return to IDLE after the line goes high.
REQ-036 Send '1', CR -> seq_err at CR, bcd outputs unchanged; then 'A'(0x41,p=1) -> seq_err; then '9','0',CR -> bcd1=9, bcd0=0, bcd_valid.
REQ-037 Send 30 back-to-back frames with zero idle gap and ±2% baud skew -> all characters received in order, no errors.
